// File: rtl/mmio_port.sv
// mmio_port: memory-mapped I/O stage between the CPU memory interface and RAM.
//
// Four reserved byte addresses are served by on-board peripherals instead of
// RAM: an LED register, a synchronized switch input, a free-running tick
// timer, and a 4-digit seven-segment hex display register. Every other
// address passes through to RAM. I/O reads use the same one-cycle latency
// as RAM reads.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low (0 = reset)
//   mem_addr   CPU address
//   mem_wr     CPU write strobe
//   mem_rd     CPU read strobe
//   wdata      CPU write data
//   ram_rdata  RAM read data, valid one cycle after the address
//   ram_wr     write strobe forwarded to RAM (suppressed for I/O addresses)
//   rdata      read data returned to the CPU
//   io_hit     current mem_addr is an I/O address (combinational)
//   SW         slide switches, asynchronous to clk
//   LEDR       LED register output
//   HEX0..HEX3 seven-segment digits, active low, {g,f,e,d,c,b,a}; HEX0 = [3:0]
module mmio_port #(
    parameter logic [7:0] LED_ADDR = 8'hF0,
    parameter logic [7:0] SW_ADDR  = 8'hF1,
    parameter logic [7:0] TMR_ADDR = 8'hF2,
    parameter logic [7:0] HEX_ADDR = 8'hF3,
    parameter int unsigned TMR_DIV = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  mem_addr,
    input  logic        mem_wr,
    input  logic        mem_rd,
    input  logic [15:0] wdata,
    input  logic [15:0] ram_rdata,
    output logic        ram_wr,
    output logic [15:0] rdata,
    output logic        io_hit,
    input  logic [9:0]  SW,
    output logic [9:0]  LEDR,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3
);

    localparam int PSC_W = (TMR_DIV > 2) ? $clog2(TMR_DIV) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(TMR_DIV - 1);

    logic [9:0]       led_q, led_d;
    logic [15:0]      hex_q, hex_d;
    logic [15:0]      tmr_q, tmr_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic [9:0]       sw_sync1_q, sw_sync2_q;
    logic             rd_sel_q, rd_sel_d;
    logic [15:0]      io_rdata_q, io_rdata_d;
    logic [15:0]      io_val;
    logic             tick;

    // Seven-segment encoder, active low, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    assign io_hit = (mem_addr == LED_ADDR) || (mem_addr == SW_ADDR) ||
                    (mem_addr == TMR_ADDR) || (mem_addr == HEX_ADDR);
    assign ram_wr = mem_wr & ~io_hit;
    assign tick   = (psc_q == PSC_LAST);

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        led_d      = led_q;
        hex_d      = hex_q;
        tmr_d      = tmr_q;
        psc_d      = tick ? '0 : psc_q + 1'b1;
        io_val     = 16'h0000;
        rd_sel_d   = 1'b0;
        io_rdata_d = io_rdata_q;

        if (tick) begin
            tmr_d = tmr_q + 16'd1;  // wraps FFFF -> 0000 silently
        end

        // A timer load overrides a tick in the same cycle.
        if (mem_wr) begin
            if (mem_addr == LED_ADDR) led_d = wdata[9:0];
            if (mem_addr == HEX_ADDR) hex_d = wdata;
            if (mem_addr == TMR_ADDR) begin
                tmr_d = wdata;
                psc_d = '0;
            end
        end

        // Read value is taken from pre-edge state, so a simultaneous write
        // to the same register returns the old contents.
        if (mem_addr == LED_ADDR)      io_val = {6'b0, led_q};
        else if (mem_addr == SW_ADDR)  io_val = {6'b0, sw_sync2_q};
        else if (mem_addr == TMR_ADDR) io_val = tmr_q;
        else if (mem_addr == HEX_ADDR) io_val = hex_q;

        if (mem_rd) begin
            rd_sel_d   = io_hit;
            io_rdata_d = io_val;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q      <= '0;
            hex_q      <= '0;
            tmr_q      <= '0;
            psc_q      <= '0;
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
            rd_sel_q   <= 1'b0;
            io_rdata_q <= '0;
        end else begin
            led_q      <= led_d;
            hex_q      <= hex_d;
            tmr_q      <= tmr_d;
            psc_q      <= psc_d;
            sw_sync1_q <= SW;          // first stage may go metastable
            sw_sync2_q <= sw_sync1_q;
            rd_sel_q   <= rd_sel_d;
            io_rdata_q <= io_rdata_d;
        end
    end

    assign rdata = rd_sel_q ? io_rdata_q : ram_rdata;
    assign LEDR  = led_q;
    assign HEX0  = seg7(hex_q[3:0]);
    assign HEX1  = seg7(hex_q[7:4]);
    assign HEX2  = seg7(hex_q[11:8]);
    assign HEX3  = seg7(hex_q[15:12]);

endmodule
